// File: rtl/fwd_ctrl.sv
// fwd_ctrl: operand-forwarding select and load-use stall for a 5-stage pipeline.
//
// Keeps a shadow copy of the destination info for the instructions in EX and
// MEM.  The ID instruction's sources are compared against these slots.  The
// mux3 selects are resolved in ID and registered, so they come straight from
// flops during EX.  The selects are 00 = register file, 01 = WB result and
// 10 = MEM ALU result.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   en                          pipeline advance (0 freezes everything)
//   flush                       squash the ID instruction (branch/jump taken)
//   id_valid, id_rs1, id_rs2    ID instruction and its source indices
//   id_rd, id_reg_write         ID destination and its write enable
//   id_mem_read                 ID instruction is a load
//   stall                       hold PC and IF/ID (combinational)
//   fwd_a, fwd_b                registered operand-A/B mux3 selects

// Resolves one source operand against the EX and MEM writers.
module fwd_ctrl_src #(
    parameter int REG_ADDR_W = 5,
    parameter bit ENABLE_FWD = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  ex_writer,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_ld,
    input  logic                  mem_writer,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  hazard,
    output logic [1:0]            fwd_nxt
);
    logic ex_hit, mem_hit;

    // The writer flags already exclude rd == x0, so x0 never matches.
    assign ex_hit  = ex_writer  && (ex_rd  == rs);
    assign mem_hit = mem_writer && (mem_rd == rs);

    generate
        if (ENABLE_FWD) begin : g_fwd
            // A load in EX has no data until after MEM, so it must wait one cycle.
            assign hazard = ex_hit && ex_ld;
            // The newest producer wins.  The EX writer will be in MEM during our EX.
            assign fwd_nxt = ex_hit  ? 2'b10 :
                             mem_hit ? 2'b01 : 2'b00;
        end else begin : g_nofwd
            assign hazard  = ex_hit || mem_hit;
            assign fwd_nxt = 2'b00;
        end
    endgenerate
endmodule

module fwd_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter bit ENABLE_FWD = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic                  stall,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);
    localparam int NUM_SRC = 2;

    // Shadow pipeline slots
    logic                  ex_v, ex_wr, ex_ld;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_v, mem_wr;
    logic [REG_ADDR_W-1:0] mem_rd;

    logic ex_writer, mem_writer;
    logic [NUM_SRC-1:0][REG_ADDR_W-1:0] rs;
    logic [NUM_SRC-1:0]                 hazard;
    logic [NUM_SRC-1:0][1:0]            fwd_nxt;

    assign ex_writer  = ex_v  && ex_wr  && (ex_rd  != '0);
    assign mem_writer = mem_v && mem_wr && (mem_rd != '0);
    assign rs         = {id_rs2, id_rs1};

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
            fwd_ctrl_src #(
                .REG_ADDR_W(REG_ADDR_W),
                .ENABLE_FWD(ENABLE_FWD)
            ) u_src (
                .rs        (rs[g]),
                .ex_writer (ex_writer),
                .ex_rd     (ex_rd),
                .ex_ld     (ex_ld),
                .mem_writer(mem_writer),
                .mem_rd    (mem_rd),
                .hazard    (hazard[g]),
                .fwd_nxt   (fwd_nxt[g])
            );
        end
    endgenerate

    // A squashed or empty ID slot never stalls.
    assign stall = id_valid && !flush && (|hazard);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_v   <= 1'b0;
            ex_wr  <= 1'b0;
            ex_ld  <= 1'b0;
            ex_rd  <= '0;
            mem_v  <= 1'b0;
            mem_wr <= 1'b0;
            mem_rd <= '0;
            fwd_a  <= 2'b00;
            fwd_b  <= 2'b00;
        end else if (en) begin
            mem_v  <= ex_v;
            mem_wr <= ex_wr;
            mem_rd <= ex_rd;
            if (flush || stall) begin
                // Insert a bubble into EX.  The bubble reads nothing, so it selects the register file.
                ex_v  <= 1'b0;
                ex_wr <= 1'b0;
                ex_ld <= 1'b0;
                ex_rd <= '0;
                fwd_a <= 2'b00;
                fwd_b <= 2'b00;
            end else begin
                ex_v  <= id_valid;
                ex_wr <= id_reg_write;
                ex_ld <= id_mem_read;
                ex_rd <= id_rd;
                fwd_a <= id_valid ? fwd_nxt[0] : 2'b00;
                fwd_b <= id_valid ? fwd_nxt[1] : 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed-vector bench for fwd_ctrl.  Each driven cycle pushes its expected
// {stall, fwd_a, fwd_b} into a scoreboard queue.  A monitor pops one entry and
// compares it at each sampling point.  Two DUTs share the stimulus: one has
// forwarding enabled and one has it disabled.  Each queue entry names which
// DUT it checks.
module tb_fwd_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1, flush = 1'b0, id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic       stall1, stall0;
    logic [1:0] fa1, fb1, fa0, fb0;
    logic       async_smp = 1'b0;

    typedef struct {
        logic       sel;   // 0: forwarding DUT, 1: no-forwarding DUT
        logic       es;
        logic [1:0] ea;
        logic [1:0] eb;
        int         tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0, cyc = 0;

    always #5 clk = ~clk;

    fwd_ctrl #(.REG_ADDR_W(5), .ENABLE_FWD(1'b1)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .stall(stall1), .fwd_a(fa1), .fwd_b(fb1)
    );

    fwd_ctrl #(.REG_ADDR_W(5), .ENABLE_FWD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .stall(stall0), .fwd_a(fa0), .fwd_b(fb0)
    );

    // Monitor: samples away from the rising edge.
    always @(negedge clk or posedge async_smp) begin
        if (q.size() > 0) begin
            exp_t e;
            logic       s;
            logic [1:0] a, b;
            e = q.pop_front();
            s = e.sel ? stall0 : stall1;
            a = e.sel ? fa0 : fa1;
            b = e.sel ? fb0 : fb1;
            checks++;
            if (s !== e.es || a !== e.ea || b !== e.eb) begin
                failures++;
                $display("FAIL c%0d dut%0d: got stall=%b fwd_a=%b fwd_b=%b, want stall=%b fwd_a=%b fwd_b=%b",
                         e.tag, e.sel, s, a, b, e.es, e.ea, e.eb);
            end
        end
    end

    task automatic push(input logic sel, input logic es, input logic [1:0] ea, input logic [1:0] eb);
        exp_t e;
        e.sel = sel; e.es = es; e.ea = ea; e.eb = eb; e.tag = cyc;
        q.push_back(e);
        cyc++;
    endtask

    // One clock cycle with full control of every input.
    task automatic step(input logic r, input logic e_n, input logic fl, input logic v,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                        input logic wr, input logic ld, input logic sel,
                        input logic es, input logic [1:0] ea, input logic [1:0] eb);
        @(posedge clk);
        #1;
        reset = r; en = e_n; flush = fl; id_valid = v;
        id_rs1 = s1; id_rs2 = s2; id_rd = d; id_reg_write = wr; id_mem_read = ld;
        push(sel, es, ea, eb);
    endtask

    task automatic ins(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic ld, input logic sel,
                       input logic es, input logic [1:0] ea, input logic [1:0] eb);
        step(1'b0, 1'b1, 1'b0, 1'b1, s1, s2, d, 1'b1, ld, sel, es, ea, eb);
    endtask

    task automatic nop(input logic sel, input logic [1:0] ea, input logic [1:0] eb);
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, sel, 1'b0, ea, eb);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        // add x5; add x6,x5,x5 -> 10/10 in the consumer's EX
        ins(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        ins(5'd5, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop(1'b0, 2'b10, 2'b10);

        // add x5; nop; sub x7,x5,x1 -> 01/00
        ins(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop(1'b0, 2'b00, 2'b00);
        ins(5'd5, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop(1'b0, 2'b01, 2'b00);

        // lw x5; add x6,x5,x2 -> one stall, then 01
        ins(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        ins(5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        ins(5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop(1'b0, 2'b01, 2'b00);

        // add x0; add x6,x0,x0 -> never forwarded
        ins(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        ins(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop(1'b0, 2'b00, 2'b00);

        // add x5; add x5; use x5 -> newest (EX) wins with 10
        ins(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        ins(5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        ins(5'd5, 5'd1, 5'd8, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop(1'b0, 2'b10, 2'b00);

        // lw x0 never stalls; MEM forward on operand B
        ins(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        ins(5'd3, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop(1'b0, 2'b00, 2'b00);
        ins(5'd1, 5'd9, 5'd10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop(1'b0, 2'b00, 2'b01);

        // lw x5; flush with dependent in ID -> no stall, EX becomes a bubble
        ins(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        ins(5'd5, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop(1'b0, 2'b01, 2'b00);

        // en = 0 for 3 cycles with a pending load-use stall and live selects
        ins(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        ins(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10);
        ins(5'd6, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10);
        ins(5'd6, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop(1'b0, 2'b01, 2'b00);

        // Reset pulse during a load-use stall with a live select
        ins(5'd7, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        ins(5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 push(1'b0, 1'b0, 2'b00, 2'b00);
        async_smp = 1'b1;
        #1 async_smp = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop(1'b0, 2'b00, 2'b00);

        // No forwarding: add x5; use x5 -> two stall cycles, selects stay 00
        ins(5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        ins(5'd5, 5'd5, 5'd6, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
        ins(5'd5, 5'd5, 5'd6, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
        ins(5'd5, 5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        nop(1'b1, 2'b00, 2'b00);

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end
endmodule
